// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / flush / halt controller.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam logic [4:0]  REG_ZERO             = 5'd0;
   localparam int unsigned DEFAULT_DRAIN_CYCLES = 4;
   localparam int unsigned DEFAULT_CNT_W        = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-status inputs and pipeline-control outputs of the hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             enable;
   logic             halt_req;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic             ex_reg_write;
   logic             mem_reg_write;
   logic             wb_reg_write;
   logic [4:0]       ex_waddr;
   logic [4:0]       mem_waddr;
   logic [4:0]       wb_waddr;
   logic             mem_branch;
   logic             mem_zero;
   logic             mem_jump;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output enable, halt_req, id_rs, id_rt, id_uses_rs, id_uses_rt,
             ex_reg_write, mem_reg_write, wb_reg_write,
             ex_waddr, mem_waddr, wb_waddr, mem_branch, mem_zero, mem_jump,
      input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
             halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  enable, halt_req, id_rs, id_rt, id_uses_rs, id_uses_rt,
             ex_reg_write, mem_reg_write, wb_reg_write,
             ex_waddr, mem_waddr, wb_waddr, mem_branch, mem_zero, mem_jump,
      output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
             halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (srst) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW-hazard stall, MEM-stage redirect flush and drain/halt sequencing for
// the 5-stage non-forwarding pipeline, with stall/flush performance counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W        = DEFAULT_CNT_W,
   parameter int unsigned DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
   parameter bit          WB_BYPASS    = 1'b0
) (
   input logic                   clk,
   input logic                   srst,
   pipeline_hazard_ctrl_if.slave bus
);

   localparam int unsigned DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   state_e          state_q, state_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic            hazard, redirect;
   logic            stall_inc, flush_inc;
   logic            pc_en, ifid_en, idex_en;
   logic            ifid_flush, idex_flush, exmem_flush, halted;

   function automatic logic src_match(
      input logic       wr,
      input logic [4:0] waddr,
      input logic       use_rs,
      input logic [4:0] rs,
      input logic       use_rt,
      input logic [4:0] rt
   );
      return wr && (waddr != REG_ZERO) &&
             ((use_rs && (rs == waddr)) || (use_rt && (rt == waddr)));
   endfunction

   always_comb begin
      hazard = src_match(bus.ex_reg_write, bus.ex_waddr, bus.id_uses_rs, bus.id_rs,
                         bus.id_uses_rt, bus.id_rt)
            || src_match(bus.mem_reg_write, bus.mem_waddr, bus.id_uses_rs, bus.id_rs,
                         bus.id_uses_rt, bus.id_rt)
            || (!WB_BYPASS &&
                src_match(bus.wb_reg_write, bus.wb_waddr, bus.id_uses_rs, bus.id_rs,
                          bus.id_uses_rt, bus.id_rt));
      redirect = bus.mem_jump || (bus.mem_branch && bus.mem_zero);
   end

   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      halted      = !srst && (state_q == ST_HALTED);

      if (srst) begin
         state_d = ST_RUN;
      end else if (!bus.enable) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         idex_en = 1'b0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (redirect) begin
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_inc   = 1'b1;
               end else begin
                  if (hazard) begin
                     pc_en      = 1'b0;
                     ifid_en    = 1'b0;
                     idex_flush = 1'b1;
                     stall_inc  = 1'b1;
                  end
                  if (bus.halt_req) begin
                     state_d = ST_DRAIN;
                     drain_d = DW'(DRAIN_CYCLES);
                  end
               end
            end
            ST_DRAIN: begin
               pc_en = 1'b0;
               if (redirect) begin
                  pc_en       = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_flush  = 1'b1;
                  exmem_flush = 1'b1;
                  flush_inc   = 1'b1;
                  drain_d     = DW'(1);
               end else if (hazard) begin
                  // stalled ID instruction is held, so no bubble into IF/ID here
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
                  stall_inc  = 1'b1;
               end else begin
                  ifid_flush = 1'b1;
                  if (drain_q <= DW'(1)) begin
                     drain_d = '0;
                     state_d = ST_HALTED;
                  end else begin
                     drain_d = drain_q - 1'b1;
                  end
               end
            end
            ST_HALTED: begin
               pc_en   = 1'b0;
               ifid_en = 1'b0;
               idex_en = 1'b0;
               if (!bus.halt_req) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q <= ST_RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .srst  (srst),
      .inc   (stall_inc),
      .count (bus.stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .srst  (srst),
      .inc   (flush_inc),
      .count (bus.flush_cnt)
   );

   assign bus.pc_en       = pc_en;
   assign bus.ifid_en     = ifid_en;
   assign bus.idex_en     = idex_en;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_flush  = idex_flush;
   assign bus.exmem_flush = exmem_flush;
   assign bus.halted      = halted;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed literal checks, then random traffic
// compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned DRAIN = 4;
   localparam int unsigned SMALL_W = 4;

   logic clk;
   logic srst;
   int   n_checks;
   int   n_fail;

   pipeline_hazard_ctrl_if #(.CNT_W(16))      bus ();
   pipeline_hazard_ctrl_if #(.CNT_W(SMALL_W)) bus4 ();

   pipeline_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN), .WB_BYPASS(1'b0)) dut (
      .clk  (clk),
      .srst (srst),
      .bus  (bus.slave)
   );

   pipeline_hazard_ctrl #(.CNT_W(SMALL_W), .DRAIN_CYCLES(DRAIN), .WB_BYPASS(1'b0)) dut4 (
      .clk  (clk),
      .srst (srst),
      .bus  (bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, halted}
   logic [6:0] ctrl, ctrl4;
   assign ctrl  = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.ifid_flush,
                   bus.idex_flush, bus.exmem_flush, bus.halted};
   assign ctrl4 = {bus4.pc_en, bus4.ifid_en, bus4.idex_en, bus4.ifid_flush,
                   bus4.idex_flush, bus4.exmem_flush, bus4.halted};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_halted;
   int m_drain_left;   // >0 while draining: non-stalled cycles still to go
   int m_stalls;
   int m_flushes;
   bit model_on;

   function automatic bit writes_src(bit wr, bit [4:0] wa);
      bit rs_hit, rt_hit;
      if (!wr || wa == 5'd0) return 1'b0;
      rs_hit = bus.id_uses_rs && (bus.id_rs == wa);
      rt_hit = bus.id_uses_rt && (bus.id_rt == wa);
      return rs_hit || rt_hit;
   endfunction

   always @(negedge clk) begin
      bit         hz, rd;
      logic [6:0] exp;
      if (model_on) begin
         hz = writes_src(bus.ex_reg_write, bus.ex_waddr) ||
              writes_src(bus.mem_reg_write, bus.mem_waddr) ||
              writes_src(bus.wb_reg_write, bus.wb_waddr);
         rd = bus.mem_jump || (bus.mem_branch && bus.mem_zero);

         chk("model_stall_cnt", 32'(bus.stall_cnt), 32'(m_stalls));
         chk("model_flush_cnt", 32'(bus.flush_cnt), 32'(m_flushes));

         if (srst) begin
            exp          = 7'b1110000;
            m_halted     = 1'b0;
            m_drain_left = 0;
            m_stalls     = 0;
            m_flushes    = 0;
         end else if (!bus.enable) begin
            exp = {6'b0, m_halted};
         end else if (m_halted) begin
            exp = 7'b0000001;
            if (!bus.halt_req) m_halted = 1'b0;
         end else if (rd) begin
            exp       = 7'b1111110;
            m_flushes = (m_flushes < 65535) ? m_flushes + 1 : m_flushes;
            if (m_drain_left > 0) m_drain_left = 1;
         end else if (hz) begin
            exp      = 7'b0010100;
            m_stalls = (m_stalls < 65535) ? m_stalls + 1 : m_stalls;
            if (m_drain_left == 0 && bus.halt_req) m_drain_left = DRAIN;
         end else if (m_drain_left > 0) begin
            exp = 7'b0111000;
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
         end else begin
            exp = 7'b1110000;
            if (bus.halt_req) m_drain_left = DRAIN;
         end
         chk("model_ctrl", 32'(ctrl), 32'(exp));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.enable        = 1'b1;
      bus.halt_req      = 1'b0;
      bus.id_rs         = 5'd0;
      bus.id_rt         = 5'd0;
      bus.id_uses_rs    = 1'b0;
      bus.id_uses_rt    = 1'b0;
      bus.ex_reg_write  = 1'b0;
      bus.mem_reg_write = 1'b0;
      bus.wb_reg_write  = 1'b0;
      bus.ex_waddr      = 5'd0;
      bus.mem_waddr     = 5'd0;
      bus.wb_waddr      = 5'd0;
      bus.mem_branch    = 1'b0;
      bus.mem_zero      = 1'b0;
      bus.mem_jump      = 1'b0;
   endtask

   task automatic ex_hazard();
      bus.ex_reg_write = 1'b1;
      bus.ex_waddr     = 5'd5;
      bus.id_rs        = 5'd5;
      bus.id_uses_rs   = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_on = 1'b1;
      srst     = 1'b1;
      idle();
      bus.enable = 1'b0;

      // constant EX hazard on the narrow-counter instance: stalls every cycle
      bus4.enable = 1'b1; bus4.halt_req = 1'b0;
      bus4.id_rs = 5'd7; bus4.id_rt = 5'd0; bus4.id_uses_rs = 1'b1; bus4.id_uses_rt = 1'b0;
      bus4.ex_reg_write = 1'b1; bus4.ex_waddr = 5'd7;
      bus4.mem_reg_write = 1'b0; bus4.mem_waddr = 5'd0;
      bus4.wb_reg_write = 1'b0; bus4.wb_waddr = 5'd0;
      bus4.mem_branch = 1'b0; bus4.mem_zero = 1'b0; bus4.mem_jump = 1'b0;

      #2 chk("reset_ctrl", 32'(ctrl), 32'h70);
      tick(); tick();
      srst = 1'b0;
      idle();
      #1;
      chk("run_idle_ctrl", 32'(ctrl), 32'h70);
      chk("reset_stall_cnt", 32'(bus.stall_cnt), 0);
      chk("reset_flush_cnt", 32'(bus.flush_cnt), 0);
      tick();

      // EX, then MEM, then WB producer of $5
      idle(); ex_hazard(); #1 chk("stall_ex", 32'(ctrl), 32'h14); tick();
      idle(); bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
      bus.mem_reg_write = 1'b1; bus.mem_waddr = 5'd5;
      #1 chk("stall_mem", 32'(ctrl), 32'h14); tick();
      idle(); bus.id_rs = 5'd5; bus.id_uses_rs = 1'b1;
      bus.wb_reg_write = 1'b1; bus.wb_waddr = 5'd5;
      #1 chk("stall_wb", 32'(ctrl), 32'h14); tick();
      idle(); #1 chk("stall_cnt_3", 32'(bus.stall_cnt), 3); tick();
      idle(); bus.ex_reg_write = 1'b1; bus.id_uses_rs = 1'b1;
      #1 chk("reg0_no_stall", 32'(ctrl), 32'h70); tick();
      idle(); #1 chk("reg0_stall_cnt", 32'(bus.stall_cnt), 3);

      // branch taken overrides a concurrent hazard
      ex_hazard(); bus.mem_branch = 1'b1; bus.mem_zero = 1'b1;
      #1 chk("redirect_ctrl", 32'(ctrl), 32'h7E); tick();
      idle(); #1;
      chk("flush_cnt_1", 32'(bus.flush_cnt), 1);
      chk("redirect_no_stall", 32'(bus.stall_cnt), 3);

      // plain drain: 4 drain cycles then halted
      bus.halt_req = 1'b1; #1 chk("halt_req_run", 32'(ctrl), 32'h70); tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         #1 chk("drain_ctrl", 32'(ctrl), 32'h38); tick();
      end
      #1 chk("halted_ctrl", 32'(ctrl), 32'h01); tick();
      #1 chk("resume_run", 32'(ctrl), 32'h70);

      // drain with one stall in the middle: 5 drain cycles
      bus.halt_req = 1'b1; #1; tick();
      idle(); #1 chk("drain2_c1", 32'(ctrl), 32'h38); tick();
      ex_hazard(); #1 chk("drain2_stall", 32'(ctrl), 32'h14); tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #1 chk("drain2_ctrl", 32'(ctrl), 32'h38); tick();
      end
      #1;
      chk("drain2_halted", 32'(ctrl), 32'h01);
      chk("drain2_stall_cnt", 32'(bus.stall_cnt), 4);
      tick();

      // jump during drain at drain_cnt=3
      bus.halt_req = 1'b1; #1 chk("drain3_run", 32'(ctrl), 32'h70); tick();
      #1 chk("drain3_c1", 32'(ctrl), 32'h38); tick();
      bus.mem_jump = 1'b1; #1 chk("drain_jump", 32'(ctrl), 32'h7E); tick();
      bus.mem_jump = 1'b0; #1;
      chk("drain_after_jump", 32'(ctrl), 32'h38);
      chk("flush_cnt_2", 32'(bus.flush_cnt), 2);
      tick();
      #1 chk("jump_halted", 32'(ctrl), 32'h01); tick();
      #1 chk("halt_held", 32'(ctrl), 32'h01);
      bus.halt_req = 1'b0; #1; tick();
      #1 chk("halt_release", 32'(ctrl), 32'h70);

      // freeze mid-stall
      ex_hazard(); #1 chk("pre_freeze", 32'(ctrl), 32'h14); tick();
      bus.enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("frozen_ctrl", 32'(ctrl), 32'h00);
         chk("frozen_stall_cnt", 32'(bus.stall_cnt), 5);
         tick();
      end
      bus.enable = 1'b1; #1 chk("unfreeze_stall", 32'(ctrl), 32'h14); tick();
      idle(); #1 chk("unfreeze_cnt", 32'(bus.stall_cnt), 6);

      // narrow counter saturates instead of wrapping
      chk("sat_stall_cnt", 32'(bus4.stall_cnt), 32'hF);
      chk("sat_flush_cnt", 32'(bus4.flush_cnt), 0);
      chk("sat_ctrl", 32'(ctrl4), 32'h14);
      tick();

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         srst              = ($urandom_range(0, 199) == 0);
         bus.enable        = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) bus.halt_req = ~bus.halt_req;
         bus.id_rs         = 5'($urandom_range(0, 3));
         bus.id_rt         = 5'($urandom_range(0, 3));
         bus.id_uses_rs    = 1'($urandom);
         bus.id_uses_rt    = 1'($urandom);
         bus.ex_reg_write  = 1'($urandom);
         bus.mem_reg_write = 1'($urandom);
         bus.wb_reg_write  = 1'($urandom);
         bus.ex_waddr      = 5'($urandom_range(0, 5));
         bus.mem_waddr     = 5'($urandom_range(0, 5));
         bus.wb_waddr      = 5'($urandom_range(0, 5));
         bus.mem_branch    = ($urandom_range(0, 4) == 0);
         bus.mem_zero      = 1'($urandom);
         bus.mem_jump      = ($urandom_range(0, 19) == 0);
         tick();
      end
      srst = 1'b0;
      idle();
      tick();
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
